// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage GPR file and HI/LO pair with same-cycle write-through bypass
module wb_regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // r0 is never written, so a write to it must not feed the bypass either
    logic gpr_wr;
    assign gpr_wr = we && (waddr != '0);

    // GPR storage: reset clears every entry, writes to r0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (gpr_wr) begin
            regs[waddr] <= wdata;
        end
    end

    // HI/LO storage: the pair is always updated together
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (whilo) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    // read port 1: reset, disable and r0 force zero; a retiring write bypasses storage
    always_comb begin
        rdata1 = '0;
        if (rst || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (gpr_wr && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    // read port 2: identical rules, independent of port 1
    always_comb begin
        rdata2 = '0;
        if (rst || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (gpr_wr && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

    // HI/LO read: a pair being written this cycle is visible immediately
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (whilo) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end else begin
            hi_o = hi_q;
            lo_o = lo_q;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile against an architectural register model
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int tests;
    int fails;
    bit chk_en;

    logic [31:0] m_regs [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // architectural state: what a program would observe after each retirement
    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else begin
            if (we && waddr != 5'd0) m_regs[waddr] = wdata;
            if (whilo) begin
                m_hi = hi_i;
                m_lo = lo_i;
            end
        end
        chk_en = 1'b1;
    end

    function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
        if (rst || !en || a == 5'd0) return 32'h0;
        if (we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_rdata1", rdata1, exp_rd(re1, raddr1));
            cmp("model_rdata2", rdata2, exp_rd(re2, raddr2));
            cmp("model_hi_o", hi_o, rst ? 32'h0 : (whilo ? hi_i : m_hi));
            cmp("model_lo_o", lo_o, rst ? 32'h0 : (whilo ? lo_i : m_lo));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        chk_en = 1'b0;
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        whilo = 1'b0; hi_i = 32'h0; lo_i = 32'h0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;
        step();
        settle();
        cmp("reset_rdata1", rdata1, 32'h0);
        cmp("reset_hi", hi_o, 32'h0);

        // reset clear
        rst = 1'b0;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        whilo = 1'b1; hi_i = 32'h1; lo_i = 32'h2;
        settle();
        cmp("t1_bypass_r5", rdata1, 32'hDEADBEEF);
        cmp("t1_bypass_hi", hi_o, 32'h1);
        step();
        we = 1'b0; whilo = 1'b0; hi_i = 32'h0; lo_i = 32'h0;
        settle();
        cmp("t1_stored_r5", rdata1, 32'hDEADBEEF);
        cmp("t1_stored_lo", lo_o, 32'h2);
        step();
        rst = 1'b1;
        settle();
        cmp("t1_inreset_r5", rdata1, 32'h0);
        cmp("t1_inreset_hi", hi_o, 32'h0);
        step();
        rst = 1'b0;
        settle();
        cmp("t1_cleared_r5", rdata1, 32'h0);
        cmp("t1_cleared_hi", hi_o, 32'h0);
        cmp("t1_cleared_lo", lo_o, 32'h0);

        // basic write/read
        step();
        we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; re1 = 1'b0;
        step();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
        settle();
        cmp("t2_r3", rdata1, 32'h12345678);
        cmp("t2_r4", rdata2, 32'h0);

        // r0 protection
        step();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        settle();
        cmp("t3_r0_same", rdata1, 32'h0);
        step();
        we = 1'b0;
        settle();
        cmp("t3_r0_next", rdata1, 32'h0);

        // bypass over an older value
        step();
        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        step();
        we = 1'b0; raddr1 = 5'd7; raddr2 = 5'd3;
        settle();
        cmp("t4_r7_old", rdata1, 32'h11111111);
        step();
        we = 1'b1; wdata = 32'h22222222; raddr1 = 5'd7; raddr2 = 5'd7;
        settle();
        cmp("t4_byp1", rdata1, 32'h22222222);
        cmp("t4_byp2", rdata2, 32'h22222222);
        step();
        re1 = 1'b0;
        settle();
        cmp("t4_re1_off", rdata1, 32'h0);
        cmp("t4_byp2_again", rdata2, 32'h22222222);
        step();
        we = 1'b0; re1 = 1'b1;
        settle();
        cmp("t4_r7_held", rdata1, 32'h22222222);

        // HI/LO bypass and hold, together with an independent GPR write
        step();
        whilo = 1'b1; hi_i = 32'hAAAA0000; lo_i = 32'h0000BBBB;
        we = 1'b1; waddr = 5'd31; wdata = 32'hC0FFEE31; raddr2 = 5'd31;
        settle();
        cmp("t5_hi_byp", hi_o, 32'hAAAA0000);
        cmp("t5_lo_byp", lo_o, 32'h0000BBBB);
        step();
        whilo = 1'b0; hi_i = 32'h0; lo_i = 32'h0; we = 1'b0;
        settle();
        cmp("t5_hi_held", hi_o, 32'hAAAA0000);
        cmp("t5_lo_held", lo_o, 32'h0000BBBB);
        cmp("t5_r31", rdata2, 32'hC0FFEE31);

        // fill every register, read back through both ports
        for (int i = 1; i < 32; i++) begin
            step();
            we = 1'b1; waddr = 5'(i); wdata = 32'h01010101 * i ^ 32'h5000_0000;
            raddr1 = 5'(i); raddr2 = 5'(i - 1);
        end
        step();
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
        end
        settle();
        cmp("fill_r31_port1", rdata1, 32'h1F1F1F1F ^ 32'h5000_0000);

        // reset priority over simultaneous writes
        step();
        rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h5A5A5A5A;
        whilo = 1'b1; hi_i = 32'h1234; lo_i = 32'h5678; raddr1 = 5'd9; raddr2 = 5'd9;
        settle();
        cmp("t6_inreset_r9", rdata1, 32'h0);
        cmp("t6_inreset_lo", lo_o, 32'h0);
        step();
        rst = 1'b0; we = 1'b0; whilo = 1'b0;
        settle();
        cmp("t6_r9", rdata1, 32'h0);
        cmp("t6_hi", hi_o, 32'h0);
        cmp("t6_lo", lo_o, 32'h0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural state sink of the write-back stage: the 32-entry general-purpose register file plus the HI/LO register pair.
- Consumes the registered write-back bundle (destination address, GPR write enable, GPR data, HI/LO write enable, HI value, LO value) directly from the MEM/WB pipeline register.
- Serves two combinational GPR read ports to the decode stage and one HI/LO read port to the execute stage.
- Write-through bypass on every read port, so a value retiring this cycle is visible to readers in the same cycle.

Parameters:
- DATA_W, 32, width of GPR, HI and LO data.
- ADDR_W, 5, GPR address width.
- REG_NUM, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high; sampled on rising clk.
- we  input  1  GPR write enable, from MEM/WB wb_wreg.
- waddr  input  ADDR_W  GPR write address, from MEM/WB wb_wd.
- wdata  input  DATA_W  GPR write data, from MEM/WB wb_wdata.
- whilo  input  1  HI/LO write enable, from MEM/WB wb_whilo.
- hi_i  input  DATA_W  HI write value, from MEM/WB wb_hi.
- lo_i  input  DATA_W  LO write value, from MEM/WB wb_lo.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data (combinational).
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data (combinational).
- hi_o  output  DATA_W  current HI, with bypass (combinational).
- lo_o  output  DATA_W  current LO, with bypass (combinational).

Behaviour:

Reset (rst = 1 at a rising clk edge):
- All REG_NUM GPRs, HI and LO are cleared to 0.
- Reset wins over any simultaneous we or whilo; the write is discarded.
- While rst is high, rdata1, rdata2, hi_o and lo_o are forced to 0 regardless of the other inputs.

GPR write:
- On a rising clk edge with rst = 0, we = 1 and waddr != 0: regs[waddr] <= wdata.
- Writes to address 0 are ignored; regs[0] reads as 0 at all times.
- Latency: written value is stored on the edge and readable from storage in the following cycle.

GPR read, port n in {1, 2}, evaluated in this priority order:
- rst = 1 -> 0.
- re_n = 0 -> 0.
- raddr_n = 0 -> 0.
- we = 1 and waddr == raddr_n -> wdata (same-cycle bypass).
- Otherwise -> regs[raddr_n].

Port independence:
- Both ports may hit the same address, or the bypass, in the same cycle; both return the same value.

HI/LO:
- On a rising clk edge with rst = 0 and whilo = 1: HI <= hi_i and LO <= lo_i, both updated together.
- No partial write of only one of the pair.
- hi_o = rst ? 0 : (whilo ? hi_i : HI).
- lo_o = rst ? 0 : (whilo ? lo_i : LO).

Simultaneous events:
- A GPR write and a HI/LO write in the same cycle are independent; both commit.
- Reset asserted mid-sequence clears all state at that edge; no pending write survives.

Other rules:
- No arithmetic is performed.
- All data paths are exactly DATA_W wide; no extension or truncation.
- Combinational read paths contain no latch. Every output is fully assigned in all branches.

Test Plan:
1. Reset clear: write 0xDEADBEEF to r5 and whilo with hi_i = 0x1, lo_i = 0x2; then hold rst = 1 for one edge and release -> re1 = 1, raddr1 = 5 gives 0; hi_o = 0, lo_o = 0.
2. Basic write/read: we = 1, waddr = 3, wdata = 0x12345678 for one edge, then we = 0 -> next cycle re1 = 1, raddr1 = 3 gives 0x12345678; re2 = 1, raddr2 = 4 gives 0.
3. r0 protection: we = 1, waddr = 0, wdata = 0xFFFFFFFF -> the same cycle and the next cycle, raddr1 = 0 with re1 = 1 gives 0.
4. Bypass: r7 holds 0x11111111; in one cycle drive we = 1, waddr = 7, wdata = 0x22222222, raddr1 = raddr2 = 7 with both enables -> rdata1 = rdata2 = 0x22222222 in that cycle, and the value is still held after the edge. With re1 = 0 in the same setup -> rdata1 = 0.
5. HI/LO bypass and hold: whilo = 1, hi_i = 0xAAAA0000, lo_i = 0x0000BBBB -> hi_o and lo_o show these values in the same cycle. After the edge with whilo = 0, they are still held.
6. Reset priority: in one cycle drive rst = 1, we = 1, waddr = 9, wdata = 0x5A5A5A5A, and whilo = 1 -> outputs are 0 during reset; after release, r9 reads 0 and HI = LO = 0.
